// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the round-robin UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } arb_state_t;

    localparam int              ARB_N        = 4;
    localparam int              ARB_IDX_W    = $clog2(ARB_N);
    localparam logic [7:0]      ARB_HDR_MARK = 8'hA0;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 valid_o,
    output logic [N-1:0]         onehot_o,
    output logic [$clog2(N)-1:0] idx_o
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    always_comb begin
        valid_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        cand     = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr_i) + i) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one fifo_uart write port among N byte-stream sources.
//  state  | meaning
//  IDLE   | no owner; pick next requester from the rr pointer
//  HEADER | owner latched; write source-ID header byte when fifo not full
//  DATA   | forward owner bytes until last, MAX_BURST, or idle timeout
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int               N         = ARB_N,
    parameter int               WIDTH     = 8,
    parameter int               MAX_BURST = 4,
    parameter int               TIMEOUT   = 8,
    parameter bit               HDR_EN    = 1'b1,
    parameter logic [WIDTH-1:0] HDR_MARK  = ARB_HDR_MARK
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [N-1:0]       i_req,
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [N-1:0]       i_last,
    output logic [N-1:0]       o_ack,
    input  logic               i_full,
    output logic               o_w_en,
    output logic [WIDTH-1:0]   o_w_data,
    output logic [N-1:0]       o_grant,
    output logic               o_abort
);
    localparam int IW  = $clog2(N);
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    arb_state_t     state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [TCW-1:0] icnt_q, icnt_d;
    logic           abort_q, abort_d;

    logic             pick_valid;
    logic [N-1:0]     pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             w_en;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] data_arr [N];
    logic [IW-1:0]    ptr_next;
    logic [BCW-1:0]   bcnt_inc;
    logic [TCW-1:0]   icnt_inc;

    rr_pick #(.N(N)) u_pick (
        .req_i    (i_req),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    always_comb begin
        for (int k = 0; k < N; k++) begin
            data_arr[k] = i_data[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            bcnt_q  <= '0;
            icnt_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            bcnt_q  <= bcnt_d;
            icnt_q  <= icnt_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        bcnt_d   = bcnt_q;
        icnt_d   = icnt_q;
        abort_d  = 1'b0;
        w_en     = 1'b0;
        w_data   = '0;
        ptr_next = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
        bcnt_inc = bcnt_q + BCW'(1);
        icnt_inc = icnt_q + TCW'(1);

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    grant_d = pick_onehot;
                    bcnt_d  = '0;
                    icnt_d  = '0;
                    state_d = HDR_EN ? HEADER : DATA;
                end
            end
            HEADER: begin
                w_en   = !i_full;
                w_data = HDR_MARK | {{(WIDTH - IW){1'b0}}, idx_q};
                if (!i_full) state_d = DATA;
            end
            DATA: begin
                w_en   = i_req[idx_q] & !i_full;
                w_data = data_arr[idx_q];
                if (w_en) begin
                    bcnt_d = bcnt_inc;
                    icnt_d = '0;
                    if (i_last[idx_q] || bcnt_inc == BCW'(MAX_BURST)) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = ptr_next;
                        bcnt_d  = '0;
                    end
                end else if (!i_req[idx_q]) begin
                    // Full-FIFO stalls leave the idle count alone; only a silent owner counts.
                    if (icnt_inc == TCW'(TIMEOUT)) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = ptr_next;
                        bcnt_d  = '0;
                        icnt_d  = '0;
                        abort_d = 1'b1;
                    end else begin
                        icnt_d = icnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset cycle must never leak a write from the packet being dropped.
    assign o_w_en   = w_en & ~i_reset;
    assign o_w_data = w_data;
    assign o_ack    = grant_q & {N{o_w_en && (state_q == DATA)}};
    assign o_grant  = grant_q;
    assign o_abort  = abort_q;

endmodule
